// File: rtl/yapay_zeka_carpim_biriktirici_pkg.sv
// Shared definitions for the AI-accelerator multiply-accumulate receiver:
// FSM state encodings and the RUN-length default shared with the controller.
package yapay_zeka_carpim_biriktirici_pkg;

  typedef enum logic [1:0] {
    YZC_BOS      = 2'd0,
    YZC_BIRIKTIR = 2'd1,
    YZC_BOSALT   = 2'd2,
    YZC_HAZIR    = 2'd3
  } yzc_durum_t;

  // Weight/data bank depth; the controller streams at most this many pairs per RUN.
  localparam int ELEMAN_SAYISI_VARS = 16;
  // Stages behind operand capture: product register, accumulator.
  localparam int BORU_DERINLIK_VARS = 2;

endpackage

// File: rtl/yapay_zeka_carpim_biriktirici_if.sv
// RUN-stream bus between the accelerator controller (master) and the
// multiply-accumulate receiver (slave); names are from the receiver's side.
interface yapay_zeka_carpim_biriktirici_if;

  logic        carpma_rst_i;
  logic [31:0] carp_deger1_i;
  logic [31:0] carp_deger2_i;
  logic [31:0] sonuc_o;
  logic        sonuc_gecerli_o;
  logic [4:0]  eleman_sayisi_o;
  logic        tasma_o;

  modport master (
    output carpma_rst_i, carp_deger1_i, carp_deger2_i,
    input  sonuc_o, sonuc_gecerli_o, eleman_sayisi_o, tasma_o
  );

  modport slave (
    input  carpma_rst_i, carp_deger1_i, carp_deger2_i,
    output sonuc_o, sonuc_gecerli_o, eleman_sayisi_o, tasma_o
  );

endinterface

// File: rtl/yapay_zeka_carpici.sv
// Registered signed 32x32 multiplier keeping the low 32 product bits, with
// enable and valid pass-through; kept separate so it can map onto DSP blocks.
module yapay_zeka_carpici (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               gecerli_i,
  input  logic signed [31:0] carp_a_i,
  input  logic signed [31:0] carp_b_i,
  output logic        [31:0] carpim_o,
  output logic               gecerli_o
);

  logic signed [31:0] w_carpim;
  logic        [31:0] r_carpim;
  logic               r_gecerli;

  // Low half of a two's-complement product is sign-agnostic, so a 32-bit context suffices.
  assign w_carpim = carp_a_i * carp_b_i;

  // NOTE: reset is checked before the enable so a stalled pipeline still empties on rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_carpim  <= '0;
      r_gecerli <= 1'b0;
    end else if (en_i) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_carpim  <= w_carpim;
      r_gecerli <= gecerli_i;
    end
  end

  assign carpim_o  = r_carpim;
  assign gecerli_o = r_gecerli;

endmodule

// File: rtl/yapay_zeka_carpim_biriktirici.sv
// Receiving end of the accelerator RUN stream: captures operand pairs, multiplies
// them (signed) and accumulates one convolution result with a valid flag.
module yapay_zeka_carpim_biriktirici
  import yapay_zeka_carpim_biriktirici_pkg::*;
#(
  parameter int ELEMAN_SAYISI = ELEMAN_SAYISI_VARS,
  parameter int BORU_DERINLIK = BORU_DERINLIK_VARS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 ddb_durdur_i,
  yapay_zeka_carpim_biriktirici_if.slave       bus
);

  yzc_durum_t  r_durum;
  logic [3:0]  r_bosalt_sayac;
  logic        r_s1_gecerli;
  logic [31:0] r_s1_veri;
  logic [31:0] r_s1_agirlik;
  logic        w_s2_gecerli;
  logic [31:0] w_s2_carpim;
  logic [31:0] r_toplam;
  logic [4:0]  r_eleman_sayisi;
  logic        r_tasma;
  logic        r_gecerli;
  logic        w_kabul;
  logic        w_baslat;

  // Pairs arriving while draining are ignored; a new RUN may start from BOS or HAZIR.
  assign w_kabul  = ~bus.carpma_rst_i && ~ddb_durdur_i && (r_durum != YZC_BOSALT);
  assign w_baslat = w_kabul && (r_durum != YZC_BIRIKTIR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_gecerli <= 1'b0;
      r_s1_veri    <= '0;
      r_s1_agirlik <= '0;
    end else if (~ddb_durdur_i) begin
      r_s1_gecerli <= w_kabul;
      if (w_kabul) begin
        r_s1_veri    <= bus.carp_deger1_i;
        r_s1_agirlik <= bus.carp_deger2_i;
      end
    end
  end

  yapay_zeka_carpici u_carpici (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (~ddb_durdur_i),
    .gecerli_i (r_s1_gecerli),
    .carp_a_i  (r_s1_veri),
    .carp_b_i  (r_s1_agirlik),
    .carpim_o  (w_s2_carpim),
    .gecerli_o (w_s2_gecerli)
  );

  // The pipeline is empty whenever a RUN starts, so clearing on start cannot drop a product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_toplam <= '0;
    end else if (~ddb_durdur_i) begin
      if (w_baslat)          r_toplam <= '0;
      else if (w_s2_gecerli) r_toplam <= r_toplam + w_s2_carpim;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum         <= YZC_BOS;
      r_bosalt_sayac  <= '0;
      r_eleman_sayisi <= '0;
      r_tasma         <= 1'b0;
      r_gecerli       <= 1'b0;
    end else if (~ddb_durdur_i) begin
      case (r_durum)
        YZC_BOS, YZC_HAZIR: begin
          if (w_kabul) begin
            r_durum         <= YZC_BIRIKTIR;
            r_eleman_sayisi <= 5'd1;
            r_tasma         <= (ELEMAN_SAYISI < 1);
            r_gecerli       <= 1'b0;
          end
        end
        YZC_BIRIKTIR: begin
          if (w_kabul) begin
            if (r_eleman_sayisi != 5'd31) r_eleman_sayisi <= r_eleman_sayisi + 5'd1;
            if (32'(r_eleman_sayisi) >= ELEMAN_SAYISI) r_tasma <= 1'b1;
          end else begin
            r_durum        <= YZC_BOSALT;
            r_bosalt_sayac <= '0;
          end
        end
        YZC_BOSALT: begin
          if (32'(r_bosalt_sayac) >= BORU_DERINLIK - 1) begin
            r_durum   <= YZC_HAZIR;
            r_gecerli <= 1'b1;
          end else begin
            r_bosalt_sayac <= r_bosalt_sayac + 4'd1;
          end
        end
        default: r_durum <= YZC_BOS;
      endcase
    end
  end

  assign bus.sonuc_o         = r_toplam;
  assign bus.sonuc_gecerli_o = r_gecerli;
  assign bus.eleman_sayisi_o = r_eleman_sayisi;
  assign bus.tasma_o         = r_tasma;

endmodule

// File: tb/tb_yapay_zeka_carpim_biriktirici.sv
// Directed self-checking bench for the RUN-stream multiply-accumulate receiver.
module tb_yapay_zeka_carpim_biriktirici;

  logic clk_i = 1'b0;
  logic rst_i;
  logic ddb_durdur_i;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  yapay_zeka_carpim_biriktirici_if bus ();

  yapay_zeka_carpim_biriktirici dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ddb_durdur_i (ddb_durdur_i),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
    bus.carpma_rst_i  = 1'b0;
    bus.carp_deger1_i = a;
    bus.carp_deger2_i = b;
    tick();
  endtask

  task automatic end_run();
    bus.carpma_rst_i  = 1'b1;
    bus.carp_deger1_i = '0;
    bus.carp_deger2_i = '0;
  endtask

  // Returns the edge count until sonuc_gecerli_o rises, or -1 when the bound expires.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (bus.sonuc_gecerli_o !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    if (bus.sonuc_gecerli_o !== 1'b1) edges = -1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ddb_durdur_i = 1'b0;
    end_run();
    tick();
    tick();
    n_compared++;
    if (bus.sonuc_o !== 32'd0) begin n_mismatched++; $display("FAIL reset_sonuc: got %h required 0", bus.sonuc_o); end
    n_compared++;
    if (bus.sonuc_gecerli_o !== 1'b0) begin n_mismatched++; $display("FAIL reset_gecerli: got %b required 0", bus.sonuc_gecerli_o); end
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd0) begin n_mismatched++; $display("FAIL reset_sayi: got %0d required 0", bus.eleman_sayisi_o); end
    n_compared++;
    if (bus.tasma_o !== 1'b0) begin n_mismatched++; $display("FAIL reset_tasma: got %b required 0", bus.tasma_o); end
    rst_i = 1'b0;
    // Zero-length RUN: idling must never raise the valid flag.
    for (int i = 0; i < 4; i++) tick();
    n_compared++;
    if (bus.sonuc_gecerli_o !== 1'b0) begin n_mismatched++; $display("FAIL idle_gecerli: got %b required 0", bus.sonuc_gecerli_o); end
  endtask

  task automatic test_basic_sum();
    int edges;
    for (int i = 1; i <= 16; i++) drive_pair(32'(i), 32'd2);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (edges != 3) begin n_mismatched++; $display("FAIL basic_latency: got %0d edges required 3", edges); end
    n_compared++;
    if (bus.sonuc_o !== 32'd272) begin n_mismatched++; $display("FAIL basic_sonuc: got %h required 110", bus.sonuc_o); end
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd16) begin n_mismatched++; $display("FAIL basic_sayi: got %0d required 16", bus.eleman_sayisi_o); end
    n_compared++;
    if (bus.tasma_o !== 1'b0) begin n_mismatched++; $display("FAIL basic_tasma: got %b required 0", bus.tasma_o); end
    tick();
    n_compared++;
    if (bus.sonuc_o !== 32'd272 || bus.sonuc_gecerli_o !== 1'b1) begin
      n_mismatched++; $display("FAIL basic_hold: got %h/%b required 110/1", bus.sonuc_o, bus.sonuc_gecerli_o);
    end
  endtask

  task automatic test_signed();
    int edges;
    drive_pair(-32'sd3, 32'sd5);
    n_compared++;
    if (bus.sonuc_gecerli_o !== 1'b0) begin n_mismatched++; $display("FAIL signed_gecerli_drop: got %b required 0", bus.sonuc_gecerli_o); end
    for (int i = 1; i < 4; i++) drive_pair(-32'sd3, 32'sd5);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'hFFFF_FFC4) begin n_mismatched++; $display("FAIL signed_sonuc: got %h required ffffffc4", bus.sonuc_o); end
    drive_pair(32'd7, 32'd7);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'd49) begin n_mismatched++; $display("FAIL signed_fresh: got %h required 31", bus.sonuc_o); end
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd1) begin n_mismatched++; $display("FAIL signed_sayi: got %0d required 1", bus.eleman_sayisi_o); end
  endtask

  task automatic test_stall();
    int edges;
    for (int i = 0; i < 4; i++) drive_pair(32'd1, 32'd1);
    ddb_durdur_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd4) begin n_mismatched++; $display("FAIL stall_sayi: got %0d required 4", bus.eleman_sayisi_o); end
    ddb_durdur_i = 1'b0;
    for (int i = 0; i < 4; i++) drive_pair(32'd1, 32'd1);
    end_run();
    tick();
    ddb_durdur_i = 1'b1;
    tick();
    n_compared++;
    if (bus.sonuc_gecerli_o !== 1'b0) begin n_mismatched++; $display("FAIL stall_drain_gecerli: got %b required 0", bus.sonuc_gecerli_o); end
    ddb_durdur_i = 1'b0;
    wait_valid(edges);
    n_compared++;
    if (edges != 2) begin n_mismatched++; $display("FAIL stall_latency: got %0d edges required 2", edges); end
    n_compared++;
    if (bus.sonuc_o !== 32'd8) begin n_mismatched++; $display("FAIL stall_sonuc: got %h required 8", bus.sonuc_o); end
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd8) begin n_mismatched++; $display("FAIL stall_sayi_end: got %0d required 8", bus.eleman_sayisi_o); end
  endtask

  task automatic test_wrap();
    int edges;
    drive_pair(32'h7FFF_FFFF, 32'd1);
    drive_pair(32'h7FFF_FFFF, 32'd1);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'hFFFF_FFFE) begin n_mismatched++; $display("FAIL wrap_sum: got %h required fffffffe", bus.sonuc_o); end
    drive_pair(32'h0001_0000, 32'h0001_0000);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'd0) begin n_mismatched++; $display("FAIL wrap_product: got %h required 0", bus.sonuc_o); end
  endtask

  task automatic test_overflow();
    int edges;
    for (int i = 0; i < 16; i++) drive_pair(32'd1, 32'd1);
    n_compared++;
    if (bus.tasma_o !== 1'b0) begin n_mismatched++; $display("FAIL ovf_at_16: got %b required 0", bus.tasma_o); end
    drive_pair(32'd1, 32'd1);
    n_compared++;
    if (bus.tasma_o !== 1'b1) begin n_mismatched++; $display("FAIL ovf_at_17: got %b required 1", bus.tasma_o); end
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'd17) begin n_mismatched++; $display("FAIL ovf_sonuc: got %h required 11", bus.sonuc_o); end
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd17) begin n_mismatched++; $display("FAIL ovf_sayi: got %0d required 17", bus.eleman_sayisi_o); end
    drive_pair(32'd4, 32'd4);
    n_compared++;
    if (bus.tasma_o !== 1'b0) begin n_mismatched++; $display("FAIL ovf_clear: got %b required 0", bus.tasma_o); end
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.sonuc_o !== 32'd16) begin n_mismatched++; $display("FAIL ovf_next: got %h required 10", bus.sonuc_o); end
    for (int i = 0; i < 33; i++) drive_pair(32'd1, 32'd1);
    end_run();
    wait_valid(edges);
    n_compared++;
    if (bus.eleman_sayisi_o !== 5'd31) begin n_mismatched++; $display("FAIL sat_sayi: got %0d required 31", bus.eleman_sayisi_o); end
    n_compared++;
    if (bus.sonuc_o !== 32'd33) begin n_mismatched++; $display("FAIL sat_sonuc: got %h required 21", bus.sonuc_o); end
  endtask

  task automatic test_mid_reset();
    int edges;
    for (int i = 0; i < 5; i++) drive_pair(32'd2, 32'd3);
    n_compared++;
    if (bus.sonuc_o !== 32'd18) begin n_mismatched++; $display("FAIL midrst_pre: got %h required 12", bus.sonuc_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    end_run();
    cmp("midrst_sonuc", bus.sonuc_o, 32'd0);
    cmp("midrst_gecerli", 32'(bus.sonuc_gecerli_o), 32'd0);
    cmp("midrst_sayi", 32'(bus.eleman_sayisi_o), 32'd0);
    cmp("midrst_tasma", 32'(bus.tasma_o), 32'd0);
    tick();
    tick();
    cmp("midrst_no_leak", bus.sonuc_o, 32'd0);
    for (int i = 0; i < 3; i++) drive_pair(32'd2, 32'd3);
    end_run();
    wait_valid(edges);
    cmp("midrst_latency", 32'(edges), 32'd3);
    cmp("midrst_fresh", bus.sonuc_o, 32'd18);
    cmp("midrst_fresh_sayi", 32'(bus.eleman_sayisi_o), 32'd3);
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_signed();
    test_stall();
    test_wrap();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
